driver_receiver: RTL
====================

DRIVER_RECEIVER -- requirements
Module: driver_receiver

Interface
REQ-001 SHALL have parameter NB_DRIVERS, default 30, number of serial data lanes (one per LED driver).
REQ-002 SHALL have parameter SR_WIDTH, default 48, driver shift-register length in bits.
REQ-003 clk_enable  in  1  clock; all logic on its rising edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 drv_sclk  in  1  driver serial clock, synchronous to clk_enable.
REQ-006 drv_lat  in  1  driver latch line, synchronous to clk_enable.
REQ-007 drv_sin  in  NB_DRIVERS  serial data, one bit per lane.
REQ-008 lane_sel  in  5  lane routed to gs_data/fc_data; values >= NB_DRIVERS select lane 0.
REQ-009 cmd_valid  out  1  one-cycle pulse, command decoded.
REQ-010 cmd  out  3  decoded command (cmd_t), held until next cmd_valid.
REQ-011 gs_data  out  SR_WIDTH  last grayscale word captured on lane_sel.
REQ-012 gs_channel  out  4  grayscale word index within current frame.
REQ-013 fc_data  out  SR_WIDTH  function-control register of lane_sel.
REQ-014 frame_done  out  1  one-cycle pulse on LATGS.
REQ-015 err_len, err_seq, err_fc_locked  out  1 each  sticky error flags.

Function
REQ-016 SHALL register drv_sclk and drv_lat each cycle; sclk rise = drv_sclk & ~sclk_q, lat fall = ~drv_lat & lat_q; sclk high and low phases each >= 1 cycle.
REQ-017 On sclk rise each lane SHALL shift MSB-first: sr <= {sr[SR_WIDTH-2:0], drv_sin[lane]}.
REQ-018 On sclk rise bit_cnt SHALL increment, saturating at 63; if drv_lat high at that rise, lat_cnt SHALL increment, saturating at 15.
REQ-019 On lat fall lat_cnt SHALL decode: 1 WRTGS, 3 LATGS, 5 WRTFC, 15 FCWRTEN, any other value UNKNOWN; cmd_valid and cmd update on the next edge (latency 1 cycle from the lat-fall cycle).
REQ-020 sclk rise and lat fall in the same cycle: the shift SHALL apply first; that rise is not counted in lat_cnt; decode uses the updated bit_cnt.
REQ-021 After decode, bit_cnt and lat_cnt SHALL clear to 0.
REQ-022 WRTGS, LATGS, WRTFC with bit_cnt != SR_WIDTH SHALL set err_len; the command still executes; FCWRTEN and UNKNOWN are exempt.
REQ-023 WRTGS: each lane SHALL copy sr into its gs_word; gs_channel increments mod 16.
REQ-024 LATGS: each lane SHALL copy sr into gs_word and pulse frame_done; if gs_channel != 15 set err_seq; gs_channel clears to 0.
REQ-025 FCWRTEN SHALL set fc_unlock; the very next decoded command of any type SHALL clear it.
REQ-026 WRTFC with fc_unlock SHALL copy sr into each lane's fc register; without fc_unlock SHALL set err_fc_locked and leave fc unchanged.
REQ-027 UNKNOWN SHALL assert cmd_valid with cmd=UNKNOWN and set err_seq, with no other effect.
REQ-028 Outputs gs_data/fc_data SHALL be combinational muxes of registered per-lane state.

Reset
REQ-029 nrst low SHALL clear all shift registers, gs_word, fc, counters, fc_unlock, cmd (=NONE), cmd_valid, frame_done, and all error flags, immediately and mid-transfer.
REQ-030 Errors SHALL clear only on reset.

Structure
REQ-031 Shared package SHALL hold cmd_t (NONE, WRTGS, LATGS, WRTFC, FCWRTEN, UNKNOWN), the LAT pulse-width constants 1/3/5/15, and SR_WIDTH.
REQ-032 One sub-module driver_rx_lane (shift register, gs_word, fc register) SHALL be instantiated NB_DRIVERS times via generate; edge detection, counters and decode stay in driver_receiver.

Verification
REQ-033 48 rises, lane 0 data 48'hA5A5_0000_FFFF, LAT high on last rise -> cmd=WRTGS, gs_data=48'hA5A5_0000_FFFF, gs_channel=1, no errors.
REQ-034 15 WRTGS + 1 LATGS frame -> frame_done pulses once, gs_channel=0, err_seq=0; repeat with 14 WRTGS -> err_seq=1.
REQ-035 WRTFC (5 LAT rises) without FCWRTEN -> err_fc_locked=1, fc_data unchanged; FCWRTEN then WRTFC 48'h0000_1234_5678 -> fc_data=48'h0000_1234_5678.
REQ-036 WRTGS after 47 rises -> err_len=1, gs word still captured; LAT held over 7 rises -> cmd=UNKNOWN, err_seq=1.
REQ-037 nrst low after 20 rises, then full 48-bit WRTGS -> all outputs zero during reset, next command correct with no err_len.

Source files
------------

// File: rtl/driver_receiver_pkg.sv
// Shared types and constants for the LED driver serial receiver.
// Holds the command encoding and LAT pulse-width values.
package driver_receiver_pkg;

   typedef enum logic [2:0] {
      NONE    = 3'd0,
      WRTGS   = 3'd1,
      LATGS   = 3'd2,
      WRTFC   = 3'd3,
      FCWRTEN = 3'd4,
      UNKNOWN = 3'd5
   } cmd_t;

   localparam int SR_WIDTH = 48;

   localparam logic [3:0] LAT_WRTGS   = 4'd1;
   localparam logic [3:0] LAT_LATGS   = 4'd3;
   localparam logic [3:0] LAT_WRTFC   = 4'd5;
   localparam logic [3:0] LAT_FCWRTEN = 4'd15;

   // Map a LAT pulse width (in sclk rises) to a command.
   function automatic cmd_t lat_decode(input logic [3:0] n);
      cmd_t c;
      case (n)
         LAT_WRTGS:   c = WRTGS;
         LAT_LATGS:   c = LATGS;
         LAT_WRTFC:   c = WRTFC;
         LAT_FCWRTEN: c = FCWRTEN;
         default:     c = UNKNOWN;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/driver_receiver_lane.sv
// One serial lane: shift register, grayscale word, FC register.
// Loads take the post-shift value so a same-cycle bit is included.
module driver_rx_lane #(
   parameter int SR_WIDTH = 48
) (
   input  logic                clk_enable,
   input  logic                nrst,
   input  logic                shift_en,
   input  logic                sin,
   input  logic                gs_load,
   input  logic                fc_load,
   output logic [SR_WIDTH-1:0] gs_word,
   output logic [SR_WIDTH-1:0] fc_word
);

   logic [SR_WIDTH-1:0] sr_q, sr_d;
   logic [SR_WIDTH-1:0] gs_q, gs_d;
   logic [SR_WIDTH-1:0] fc_q, fc_d;

   // Next state: shift MSB-first, then optional capture.
   always_comb begin
      sr_d = shift_en ? {sr_q[SR_WIDTH-2:0], sin} : sr_q;
      gs_d = gs_load ? sr_d : gs_q;
      fc_d = fc_load ? sr_d : fc_q;
   end

   // Lane state registers.
   always_ff @(posedge clk_enable or negedge nrst) begin
      if (!nrst) begin
         sr_q <= '0;
         gs_q <= '0;
         fc_q <= '0;
      end else begin
         sr_q <= sr_d;
         gs_q <= gs_d;
         fc_q <= fc_d;
      end
   end

   assign gs_word = gs_q;
   assign fc_word = fc_q;

endmodule

// File: rtl/driver_receiver.sv
// Receiver for LED driver serial traffic: edge detect, counters,
// LAT-width command decode and per-lane capture control.
module driver_receiver #(
   parameter int NB_DRIVERS = 30,
   parameter int SR_WIDTH   = driver_receiver_pkg::SR_WIDTH
) (
   input  logic                    clk_enable,
   input  logic                    nrst,
   input  logic                    drv_sclk,
   input  logic                    drv_lat,
   input  logic [NB_DRIVERS-1:0]   drv_sin,
   input  logic [4:0]              lane_sel,
   output logic                    cmd_valid,
   output driver_receiver_pkg::cmd_t cmd,
   output logic [SR_WIDTH-1:0]     gs_data,
   output logic [3:0]              gs_channel,
   output logic [SR_WIDTH-1:0]     fc_data,
   output logic                    frame_done,
   output logic                    err_len,
   output logic                    err_seq,
   output logic                    err_fc_locked
);
   import driver_receiver_pkg::*;

   localparam logic [5:0] SR_LEN = 6'(SR_WIDTH);

   logic       sclk_q, lat_q;
   logic       sclk_rise, lat_fall;
   logic [5:0] bit_cnt_q, bit_cnt_d, bit_cnt_inc;
   logic [3:0] lat_cnt_q, lat_cnt_d, lat_cnt_inc;
   logic [3:0] gs_channel_q, gs_channel_d;
   cmd_t       cmd_q, cmd_d, dec_cmd;
   logic       cmd_valid_q, cmd_valid_d;
   logic       frame_done_q, frame_done_d;
   logic       fc_unlock_q, fc_unlock_d;
   logic       err_len_q, err_len_d;
   logic       err_seq_q, err_seq_d;
   logic       err_fc_q, err_fc_d;
   logic       gs_load, fc_load;
   logic [4:0] sel;

   logic [SR_WIDTH-1:0] gs_arr [NB_DRIVERS];
   logic [SR_WIDTH-1:0] fc_arr [NB_DRIVERS];

   // Edge detect, counting, decode and command execution.
   always_comb begin
      sclk_rise = drv_sclk & ~sclk_q;
      lat_fall  = ~drv_lat & lat_q;

      bit_cnt_inc = bit_cnt_q;
      if (sclk_rise && bit_cnt_q != 6'd63)
         bit_cnt_inc = bit_cnt_q + 6'd1;
      lat_cnt_inc = lat_cnt_q;
      if (sclk_rise && drv_lat && lat_cnt_q != 4'd15)
         lat_cnt_inc = lat_cnt_q + 4'd1;
      dec_cmd = lat_decode(lat_cnt_inc);

      bit_cnt_d    = bit_cnt_inc;
      lat_cnt_d    = lat_cnt_inc;
      cmd_d        = cmd_q;
      cmd_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      gs_channel_d = gs_channel_q;
      fc_unlock_d  = fc_unlock_q;
      err_len_d    = err_len_q;
      err_seq_d    = err_seq_q;
      err_fc_d     = err_fc_q;
      gs_load      = 1'b0;
      fc_load      = 1'b0;

      if (lat_fall) begin
         bit_cnt_d   = '0;
         lat_cnt_d   = '0;
         cmd_d       = dec_cmd;
         cmd_valid_d = 1'b1;
         fc_unlock_d = 1'b0;
         if ((dec_cmd == WRTGS || dec_cmd == LATGS ||
              dec_cmd == WRTFC) && bit_cnt_inc != SR_LEN)
            err_len_d = 1'b1;
         case (dec_cmd)
            WRTGS: begin
               gs_load      = 1'b1;
               gs_channel_d = gs_channel_q + 4'd1;
            end
            LATGS: begin
               gs_load      = 1'b1;
               frame_done_d = 1'b1;
               gs_channel_d = '0;
               if (gs_channel_q != 4'd15)
                  err_seq_d = 1'b1;
            end
            WRTFC: begin
               if (fc_unlock_q) fc_load = 1'b1;
               else             err_fc_d = 1'b1;
            end
            FCWRTEN: fc_unlock_d = 1'b1;
            default: err_seq_d = 1'b1;
         endcase
      end
   end

   // Control and status registers.
   always_ff @(posedge clk_enable or negedge nrst) begin
      if (!nrst) begin
         sclk_q       <= 1'b0;
         lat_q        <= 1'b0;
         bit_cnt_q    <= '0;
         lat_cnt_q    <= '0;
         gs_channel_q <= '0;
         cmd_q        <= NONE;
         cmd_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         fc_unlock_q  <= 1'b0;
         err_len_q    <= 1'b0;
         err_seq_q    <= 1'b0;
         err_fc_q     <= 1'b0;
      end else begin
         sclk_q       <= drv_sclk;
         lat_q        <= drv_lat;
         bit_cnt_q    <= bit_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         gs_channel_q <= gs_channel_d;
         cmd_q        <= cmd_d;
         cmd_valid_q  <= cmd_valid_d;
         frame_done_q <= frame_done_d;
         fc_unlock_q  <= fc_unlock_d;
         err_len_q    <= err_len_d;
         err_seq_q    <= err_seq_d;
         err_fc_q     <= err_fc_d;
      end
   end

   for (genvar g = 0; g < NB_DRIVERS; g++) begin : g_lane
      driver_rx_lane #(.SR_WIDTH(SR_WIDTH)) u_lane (
         .clk_enable (clk_enable),
         .nrst       (nrst),
         .shift_en   (sclk_rise),
         .sin        (drv_sin[g]),
         .gs_load    (gs_load),
         .fc_load    (fc_load),
         .gs_word    (gs_arr[g]),
         .fc_word    (fc_arr[g])
      );
   end

   // Lane readback mux; out-of-range selects fall back to lane 0.
   always_comb begin
      sel     = (int'(lane_sel) < NB_DRIVERS) ? lane_sel : 5'd0;
      gs_data = gs_arr[sel];
      fc_data = fc_arr[sel];
   end

   assign cmd_valid     = cmd_valid_q;
   assign cmd           = cmd_q;
   assign gs_channel    = gs_channel_q;
   assign frame_done    = frame_done_q;
   assign err_len       = err_len_q;
   assign err_seq       = err_seq_q;
   assign err_fc_locked = err_fc_q;

endmodule
